// File: rtl/id_ex_reg_pkg.sv
// Shared ID/EX pipeline field definitions: ALU op encodings, specifier width,
// packed control vector and the bubble control constant.
package id_ex_reg_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD    = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB    = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_R_TYPE = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND    = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR     = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT    = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LUI    = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP    = 3'b111;

  typedef struct packed {
    logic                valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                reg_dst;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_write;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Bubble: no side effects anywhere downstream, ALU told to do nothing.
  localparam ctrl_t CTRL_BUBBLE = '{
    valid:      1'b0,
    alu_op:     ALU_OP_NOP,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    branch:     1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0
  };

endpackage

// File: rtl/id_ex_reg_stage_reg.sv
// Generic pipeline stage register: reset > hold > flush > load, all synchronous.
module stage_reg #(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)      q <= RST_VAL;
    else if (hold)  q <= q;
    else if (flush) q <= flush_val;
    else            q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with hold, flush, valid flag and saturating bubble count.
// Optional WB-to-EX operand bypass enabled by defining ID_EX_WB_BYPASS_EN.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [DATA_W-1:0]   id_pc4,
  input  logic [DATA_W-1:0]   id_rd1,
  input  logic [DATA_W-1:0]   id_rd2,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_alu_src,
  input  logic                id_reg_dst,
  input  logic                id_branch,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_reg_write,
  input  logic                wb_reg_write,
  input  logic [REG_W-1:0]    wb_write_reg,
  input  logic [DATA_W-1:0]   wb_write_data,
  output logic                ex_valid,
  output logic [DATA_W-1:0]   ex_pc4,
  output logic [DATA_W-1:0]   ex_rd1,
  output logic [DATA_W-1:0]   ex_rd2,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [5:0]          ex_funct,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [REG_W-1:0]    ex_rd,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_alu_src,
  output logic                ex_reg_dst,
  output logic                ex_branch,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_reg_write,
  output logic [CNT_W-1:0]    bubble_count
);

  localparam int unsigned DVEC_W = 4 * DATA_W + 3 * REG_W;

  ctrl_t              ctrl_d;
  ctrl_t              ctrl_q;
  logic [DATA_W-1:0]  rd1_d;
  logic [DATA_W-1:0]  rd2_d;
  logic [DVEC_W-1:0]  dvec_d;
  logic [DVEC_W-1:0]  dvec_q;

`ifdef ID_EX_WB_BYPASS_EN
  // Same-cycle WB write forwarded into the captured operands ($0 never forwards).
  always_comb begin
    rd1_d = id_rd1;
    rd2_d = id_rd2;
    if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == id_rs)) rd1_d = wb_write_data;
    if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == id_rt)) rd2_d = wb_write_data;
  end
`else
  logic unused_wb;
  assign unused_wb = &{1'b0, wb_reg_write, wb_write_reg, wb_write_data};
  assign rd1_d = id_rd1;
  assign rd2_d = id_rd2;
`endif

  // Upstream bubbles (id_valid = 0) still get their control forced inert.
  always_comb begin
    ctrl_d = CTRL_BUBBLE;
    if (id_valid) begin
      ctrl_d.valid      = 1'b1;
      ctrl_d.alu_op     = id_alu_op;
      ctrl_d.alu_src    = id_alu_src;
      ctrl_d.reg_dst    = id_reg_dst;
      ctrl_d.branch     = id_branch;
      ctrl_d.mem_read   = id_mem_read;
      ctrl_d.mem_write  = id_mem_write;
      ctrl_d.mem_to_reg = id_mem_to_reg;
      ctrl_d.reg_write  = id_reg_write;
    end
  end

  assign dvec_d = {id_pc4, rd1_d, rd2_d, id_imm, id_rs, id_rt, id_rd};

  stage_reg #(.WIDTH(CTRL_W), .RST_VAL(CTRL_BUBBLE)) u_ctrl_reg (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .flush     (flush),
    .flush_val (CTRL_BUBBLE),
    .d         (ctrl_d),
    .q         (ctrl_q)
  );

  stage_reg #(.WIDTH(DVEC_W), .RST_VAL('0)) u_data_reg (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .flush     (flush),
    .flush_val ('0),
    .d         (dvec_d),
    .q         (dvec_q)
  );

  // Counts only bubbles inserted here by flush, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      bubble_count <= '0;
    else if (!hold && flush && (bubble_count != '1))
      bubble_count <= bubble_count + CNT_W'(1);
  end

  assign {ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd} = dvec_q;
  assign ex_funct      = ex_imm[5:0];
  assign ex_valid      = ctrl_q.valid;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_branch     = ctrl_q.branch;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;

endmodule
